seg7_scan: RTL and testbench



---
 rtl/seg7_pkg.sv | 16 +
 rtl/seg7_decode.sv | 11 +
 rtl/seg7_scan.sv | 116 +++++++++++
 tb/tb_seg7_scan.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared constants for the eight-digit seven-segment scanner.
// Segment patterns are active-low, ordered a (bit 6) down to g (bit 0).
package seg7_pkg;

    localparam int NUM_DIGITS = 8;
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [7:0] AN_OFF = 8'hFF;

    localparam logic [6:0] SEG_TABLE [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

endpackage

// File: rtl/seg7_decode.sv
// Combinational hex nibble to active-low seven-segment pattern.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);

    assign seg_o = SEG_TABLE[nibble_i];

endmodule

// File: rtl/seg7_scan.sv
// Time-multiplexed Nexys4 eight-digit display driver with frame-synchronous double buffering.
// Optional leading-zero blanking is enabled by defining SEG7_LZB_EN.
module seg7_scan
    import seg7_pkg::*;
#(
    parameter int TICK_DIV = 100000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] value,
    input  logic        load,
    input  logic [7:0]  digit_en,
    input  logic [7:0]  dp_in,
    output logic        pending,
    output logic [6:0]  a_to_g,
    output logic [7:0]  an,
    output logic        dp
);

    localparam int CW = $clog2(TICK_DIV);
    localparam logic [CW-1:0] TICK_LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0]           tick_q, tick_d;
    logic [2:0]              idx_q, idx_d;
    logic [31:0]             shadow_q, shadow_d;
    logic [31:0]             display_q, display_d;
    logic                    pending_q, pending_d;
    logic [7:0]              an_q, an_d;
    logic [6:0]              seg_q, seg_d;
    logic                    dp_q, dp_d;
    logic                    slotWrap;
    logic                    frameEnd;
    logic [3:0]              nibble;
    logic [6:0]              decoded;
    logic                    showDigit;
    logic [NUM_DIGITS-1:0]   keep;

    assign slotWrap = (tick_q == TICK_LAST);
    assign frameEnd = slotWrap && (idx_q == 3'd7);
    assign nibble   = display_q[{idx_q, 2'b00} +: 4];

    seg7_decode u_decode (
        .nibble_i (nibble),
        .seg_o    (decoded)
    );

`ifdef SEG7_LZB_EN
    // A digit stays lit only if some nibble at or above it is non-zero; digit 0 always stays.
    always_comb begin
        keep    = '0;
        keep[0] = 1'b1;
        for (int i = 1; i < NUM_DIGITS; i++) begin
            keep[i] = ((display_q >> (4 * i)) != 32'd0);
        end
    end
`else
    assign keep = '1;
`endif

    assign showDigit = digit_en[idx_q] & keep[idx_q];

    always_comb begin
        tick_d    = slotWrap ? '0 : tick_q + 1'b1;
        idx_d     = slotWrap ? idx_q + 3'd1 : idx_q;
        shadow_d  = shadow_q;
        display_d = display_q;
        pending_d = pending_q;

        // Display takes the old shadow at the boundary; a coincident load re-arms pending.
        if (frameEnd && pending_q) begin
            display_d = shadow_q;
            pending_d = 1'b0;
        end
        if (load) begin
            shadow_d  = value;
            pending_d = 1'b1;
        end

        an_d  = AN_OFF;
        seg_d = SEG_BLANK;
        dp_d  = 1'b1;
        if (showDigit) begin
            an_d  = ~(8'b1 << idx_q);
            seg_d = decoded;
            dp_d  = ~dp_in[idx_q];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_q    <= '0;
            idx_q     <= 3'd0;
            shadow_q  <= 32'd0;
            display_q <= 32'd0;
            pending_q <= 1'b0;
            an_q      <= AN_OFF;
            seg_q     <= SEG_BLANK;
            dp_q      <= 1'b1;
        end else begin
            tick_q    <= tick_d;
            idx_q     <= idx_d;
            shadow_q  <= shadow_d;
            display_q <= display_d;
            pending_q <= pending_d;
            an_q      <= an_d;
            seg_q     <= seg_d;
            dp_q      <= dp_d;
        end
    end

    assign pending = pending_q;
    assign an      = an_q;
    assign a_to_g  = seg_q;
    assign dp      = dp_q;

endmodule

// File: tb/tb_seg7_scan.sv
// Self-checking bench for seg7_scan: directed scenarios plus random loads against a cycle-count reference model.
module tb_seg7_scan;

    localparam int TICK  = 4;
    localparam int FRAME = 8 * TICK;

    logic        clk;
    logic        rst_n;
    logic [31:0] value;
    logic        load;
    logic [7:0]  digit_en;
    logic [7:0]  dp_in;
    logic        pending;
    logic [6:0]  a_to_g;
    logic [7:0]  an;
    logic        dp;

    int nChecks = 0;
    int nPass   = 0;
    int nFail   = 0;

    int          mCyc;
    logic [31:0] mShadow;
    logic [31:0] mDisp;
    logic        mPend;
    logic [7:0]  expAn;
    logic [6:0]  expSeg;
    logic        expDp;

    logic [6:0] segRef [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    seg7_scan #(.TICK_DIV(TICK)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .value    (value),
        .load     (load),
        .digit_en (digit_en),
        .dp_in    (dp_in),
        .pending  (pending),
        .a_to_g   (a_to_g),
        .an       (an),
        .dp       (dp)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        assert (obs === exp) nPass++;
        else begin
            nFail++;
            $error("[TB] FAIL %s at cycle %0d: got %h, expected %h", tag, mCyc, obs, exp);
        end
    endtask

    task automatic checkAll(input string tag);
        checkOutput({tag, ".an"}, {24'd0, an}, {24'd0, expAn});
        checkOutput({tag, ".seg"}, {25'd0, a_to_g}, {25'd0, expSeg});
        checkOutput({tag, ".dp"}, {31'd0, dp}, {31'd0, expDp});
        checkOutput({tag, ".pending"}, {31'd0, pending}, {31'd0, mPend});
    endtask

    task automatic resetModel();
        mCyc    = 0;
        mShadow = 32'd0;
        mDisp   = 32'd0;
        mPend   = 1'b0;
        expAn   = 8'hFF;
        expSeg  = 7'h7F;
        expDp   = 1'b1;
    endtask

    // Slot position follows directly from the cycle count since reset release.
    task automatic modelEdge();
        int slot;
        logic show;
        logic [3:0] nib;
        slot = (mCyc / TICK) % 8;
        nib  = 4'((mDisp >> (4 * slot)) & 32'hF);
        show = digit_en[slot];
`ifdef SEG7_LZB_EN
        if (slot != 0 && (mDisp >> (4 * slot)) == 32'd0) show = 1'b0;
`endif
        if (show) begin
            expAn  = 8'hFF - (8'd1 << slot);
            expSeg = segRef[nib];
            expDp  = !dp_in[slot];
        end else begin
            expAn  = 8'hFF;
            expSeg = 7'h7F;
            expDp  = 1'b1;
        end
        if ((mCyc % FRAME) == FRAME - 1 && mPend) begin
            mDisp = mShadow;
            mPend = 1'b0;
        end
        if (load) begin
            mShadow = value;
            mPend   = 1'b1;
        end
        mCyc++;
    endtask

    task automatic cycle(input string tag);
        @(posedge clk);
        modelEdge();
        @(negedge clk);
        checkAll(tag);
    endtask

    task automatic runCycles(input int n, input string tag);
        for (int i = 0; i < n; i++) cycle(tag);
    endtask

    task automatic applyStimulus(input logic [31:0] v, input string tag);
        value = v;
        load  = 1'b1;
        cycle(tag);
        load  = 1'b0;
    endtask

    task automatic alignTo(input int pos, input string tag);
        while ((mCyc % FRAME) != pos) cycle(tag);
    endtask

    initial begin
        rst_n    = 1'b0;
        load     = 1'b0;
        value    = 32'd0;
        digit_en = 8'hFF;
        dp_in    = 8'h00;
        resetModel();

        repeat (3) @(negedge clk);
        checkAll("reset");
        rst_n = 1'b1;

        $display("[TB] initial load and full scan");
        applyStimulus(32'h89ABCDEF, "load0");
        runCycles(2 * FRAME, "scan0");

        $display("[TB] anti-tear mid-frame load");
        alignTo(12, "align1");
        applyStimulus(32'h00000001, "tear");
        runCycles(FRAME + 4, "tear_run");

        $display("[TB] back-to-back loads");
        alignTo(3, "align2");
        applyStimulus(32'h11111111, "b2b_a");
        runCycles(5, "b2b_gap");
        applyStimulus(32'h22222222, "b2b_b");
        runCycles(FRAME + 2, "b2b_run");

        $display("[TB] load coincident with frame boundary");
        applyStimulus(32'h76543210, "pre_edge");
        alignTo(FRAME - 1, "align3");
        applyStimulus(32'hFEDCBA98, "edge_load");
        runCycles(2 * FRAME, "edge_run");

        $display("[TB] blanking and decimal points");
        digit_en = 8'b0000_0101;
        dp_in    = 8'b0000_0100;
        runCycles(FRAME, "blank");

        $display("[TB] leading-zero patterns");
        digit_en = 8'hFF;
        dp_in    = 8'h00;
        applyStimulus(32'h00000A00, "lzb_a00");
        runCycles(2 * FRAME, "lzb_run1");
        applyStimulus(32'h00000000, "lzb_zero");
        runCycles(2 * FRAME, "lzb_run2");

        $display("[TB] randomized traffic");
        for (int i = 0; i < 400; i++) begin
            load  = ($urandom_range(0, 9) == 0);
            value = $urandom >> (4 * $urandom_range(0, 8));
            if ($urandom_range(0, 15) == 0) digit_en = 8'($urandom);
            dp_in = 8'($urandom);
            cycle("rand");
        end
        load = 1'b0;

        $display("[TB] asynchronous reset with pending value");
        digit_en = 8'hFF;
        applyStimulus(32'h5A5A5A5A, "pre_rst");
        runCycles(2, "pre_rst_run");
        #2;
        rst_n = 1'b0;
        resetModel();
        #1;
        checkAll("async_rst");
        @(negedge clk);
        checkAll("rst_hold");
        rst_n = 1'b1;
        runCycles(FRAME + 4, "post_rst");

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
